// File: rtl/pc_sequencer_if.sv
// Control-unit to program-counter bundle: strobes and target in, fetch address and status out.
// ADDR_WIDTH and STACK_DEPTH must match the pc_sequencer instance they connect to.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 11,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                  stall;
    logic                  branch;
    logic                  call;
    logic                  ret;
    logic                  irq;
    logic                  irq_enable;
    logic                  clear_flags;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  running;
    logic                  irq_ack;
    logic [DEPTH_W-1:0]    depth;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output stall, branch, call, ret, irq, irq_enable, clear_flags, target,
        input  pc, running, irq_ack, depth, overflow, underflow
    );

    modport slave (
        input  stall, branch, call, ret, irq, irq_enable, clear_flags, target,
        output pc, running, irq_ack, depth, overflow, underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with post-reset hold window, hardware return stack and vectored irq entry.
// All state advances on the falling edge of clock.
//
// state | meaning
// HOLD  | pc pinned at RESET_VECTOR while the hold counter runs down; inputs ignored
// RUN   | one action per edge: stall > irq > ret > call > branch > increment
module pc_sequencer #(
    parameter int ADDR_WIDTH        = 11,
    parameter int RESET_VECTOR      = 0,
    parameter int IRQ_VECTOR        = 2,
    parameter int RESET_HOLD_CYCLES = 1,
    parameter int STACK_DEPTH       = 4
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int HOLD_W  = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] IRQ_PC   = ADDR_WIDTH'(IRQ_VECTOR);
    localparam logic [DEPTH_W-1:0]    FULL     = DEPTH_W'(STACK_DEPTH);
    localparam logic [HOLD_W-1:0]     HOLD_LD  = HOLD_W'(RESET_HOLD_CYCLES);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (RESET_HOLD_CYCLES == 0) ? RUN : HOLD;
    localparam logic   RESET_RUN   = (RESET_HOLD_CYCLES == 0);

    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  running_q;
    logic                  irq_ack_q;
    logic [DEPTH_W-1:0]    depth_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [ADDR_WIDTH-1:0] stack [0:(1<<PTR_W)-1];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  irq_take;
    logic                  do_ret;
    logic                  do_call;
    logic                  push_req;
    logic [ADDR_WIDTH-1:0] push_val;
    logic                  stack_full;
    logic                  stack_empty;
    logic [PTR_W-1:0]      push_ptr;
    logic [PTR_W-1:0]      top_ptr;

    always_comb begin
        pc_inc      = pc_q + 1'b1;
        stack_full  = (depth_q == FULL);
        stack_empty = (depth_q == '0);
        push_ptr    = PTR_W'(depth_q);
        top_ptr     = PTR_W'(depth_q - 1'b1);
        irq_take    = !bus.stall && bus.irq && bus.irq_enable;
        do_ret      = !bus.stall && !irq_take && bus.ret;
        do_call     = !bus.stall && !irq_take && !bus.ret && bus.call;
        push_req    = irq_take || do_call;
        push_val    = irq_take ? pc_q : pc_inc;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state       <= RESET_STATE;
            hold_cnt    <= HOLD_LD;
            pc_q        <= RST_PC;
            running_q   <= RESET_RUN;
            irq_ack_q   <= 1'b0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < (1 << PTR_W); i++) begin
                stack[i] <= '0;
            end
        end else begin
            case (state)
                HOLD: begin
                    pc_q      <= RST_PC;
                    irq_ack_q <= 1'b0;
                    if (hold_cnt <= HOLD_W'(1)) begin
                        hold_cnt  <= '0;
                        state     <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RUN: begin
                    irq_ack_q <= irq_take;
                    // Clears are scheduled first so a same-edge set overrides them.
                    if (bus.clear_flags) begin
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                    end
                    if (push_req) begin
                        if (stack_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            stack[push_ptr] <= push_val;
                            depth_q         <= depth_q + 1'b1;
                        end
                    end
                    if (bus.stall) begin
                        pc_q <= pc_q;
                    end else if (irq_take) begin
                        pc_q <= IRQ_PC;
                    end else if (do_ret) begin
                        if (stack_empty) begin
                            pc_q        <= RST_PC;
                            underflow_q <= 1'b1;
                        end else begin
                            pc_q    <= stack[top_ptr];
                            depth_q <= depth_q - 1'b1;
                        end
                    end else if (do_call || bus.branch) begin
                        pc_q <= bus.target;
                    end else begin
                        pc_q <= pc_inc;
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

    // With no hold window running must rise the moment reset releases, not a clock later.
    assign bus.running   = running_q & ~reset;
    assign bus.pc        = pc_q;
    assign bus.irq_ack   = irq_ack_q;
    assign bus.depth     = depth_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
